player_physics: RTL and testbench
=================================

Name: player_physics

Overview:
Per-frame vertical physics engine for the player cube. Produces the player's Y position and feeds it directly to the VGA sprite renderer's player_y_pos input, replacing software writes of that register. Updates once per frame on a vblank tick. Handles jump, gravity, terminal velocity, landing on the floor surface below the player, walking off edges, and crash detection.

Parameters:
GROUND_Y, 400, reset/restart Y of the sprite top edge, in pixels (Y axis points down, as vcount does)
JUMP_VEL, 160, initial upward speed, 1/16 px per frame
GRAVITY, 10, downward acceleration, 1/16 px per frame per frame
MAX_FALL, 192, terminal downward speed, 1/16 px per frame
STEP_MAX, 4, largest floor rise (px) absorbed by snapping up instead of crashing

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame at start of vertical blanking
enable  in  1  level; when low, ticks are ignored (pause)
restart  in  1  one-cycle pulse; return to the reset state
jump  in  1  level; sampled only on frame_tick
floor_y  in  10  Y (px) at which the sprite top rests on the surface under the player; 480 means no floor
player_y_pos  out  16  {6'b0, integer Y}; connects to the sprite renderer
on_ground  out  1  high in GROUNDED
landed  out  1  one-cycle pulse on the update that lands
crash  out  1  sticky; set on side collision

Behaviour:
- Internal state:
  - pos: unsigned Q10.4, 14 bits
  - vel: signed Q8.4, 12 bits; positive means down
  - FSM: GROUNDED, AIR, CRASHED
- Reset and restart (restart takes the same path; reset has priority over everything):
  - pos=GROUNDED_Y<<4 (GROUND_Y<<4), vel=0, state GROUNDED
  - on_ground=1, landed=0, crash=0, player_y_pos=GROUND_Y
- Updates occur only on a cycle with frame_tick && enable && !restart. Registered results are visible the next cycle (1-cycle latency). player_y_pos holds between ticks.
- GROUNDED:
  - If pos_int > floor_y+STEP_MAX: go CRASHED, crash=1.
  - Else if pos_int > floor_y: snap up, pos=floor_y<<4.
  - Else if jump: v0=-JUMP_VEL; pos+=v0; vel=v0+GRAVITY; go AIR.
  - Else if floor_y > pos_int (walked off an edge): vel=GRAVITY, go AIR (pos unchanged this tick).
- AIR:
  - pos_next = pos+vel, computed in 15-bit signed arithmetic.
  - vel_next = min(vel+GRAVITY, MAX_FALL).
  - If pos_next < 0: pos=0 and vel=0 (ceiling clamp); stay AIR.
  - Else if pos_next >= floor_y<<4:
    - If pos_int > floor_y+STEP_MAX (pre-update, side hit): CRASHED.
    - Otherwise: pos=floor_y<<4, vel=0, GROUNDED, landed=1 for one cycle.
  - Otherwise: pos=pos_next, vel=vel_next.
- CRASHED: pos and vel frozen, crash=1, jump ignored. Exits only via restart or reset.
- landed is deasserted on every cycle other than the landing update.
- floor_y=480 with no landing: pos keeps rising toward 480<<4. The renderer clips the sprite.
- enable low mid-air: state frozen exactly; resumes on the next enabled tick.
- restart coincident with frame_tick: restart wins, no physics update.

Test Plan:
- Reset, floor_y=400, no jump, 10 ticks -> player_y_pos=400, on_ground=1, landed=0, crash=0 throughout.
- floor_y=400, jump held for tick 1 only:
  - tick1 -> y=390
  - tick2 -> y=380 (pos 380.625)
  - apex after tick16
  - tick33 -> y=400, landed pulse exactly one cycle, on_ground=1
- jump held continuously -> lands at tick33; tick34 starts a new jump, y=390.
- Grounded at 400, floor_y drops to 480 -> y increases by 0, 0.625, 1.25 ... px per tick; vel saturates at 192 (12 px/frame) and never exceeds it.
- Floor rises:
  - Grounded at 400, floor_y=397 -> next tick y=397, no crash.
  - floor_y=390 -> crash=1, y frozen; a following jump has no effect.
  - restart -> y=400, crash=0.
- Mid-air (y≈385) with enable=0 for 5 ticks -> y unchanged. Then reset mid-air -> y=400, GROUNDED on the next cycle.

Source files
------------

// File: rtl/player_physics.sv
// Per-frame vertical physics for the player sprite: jump, gravity, terminal
// velocity, landing, edge walk-off and side-crash detection, stepped on frame_tick.
//
// state    | meaning
// GROUNDED | resting on floor_y, vel = 0
// AIR      | ballistic motion, pos/vel integrate each enabled tick
// CRASHED  | side collision, frozen until restart or reset
module player_physics #(
    parameter int GROUND_Y = 400,
    parameter int JUMP_VEL = 160,
    parameter int GRAVITY  = 10,
    parameter int MAX_FALL = 192,
    parameter int STEP_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic        restart,
    input  logic        jump,
    input  logic [9:0]  floor_y,
    output logic [15:0] player_y_pos,
    output logic        on_ground,
    output logic        landed,
    output logic        crash
);

    typedef enum logic [1:0] {GROUNDED, AIR, CRASHED} state_t;

    localparam logic [13:0]        GROUND_POS = 14'(GROUND_Y * 16);
    localparam logic signed [11:0] GRAV       = 12'(GRAVITY);
    localparam logic signed [11:0] MAX_V      = 12'(MAX_FALL);
    localparam logic signed [11:0] JUMP_V0    = 12'(-JUMP_VEL);

    state_t             state, state_next;
    logic [13:0]        pos, pos_next;
    logic signed [11:0] vel, vel_next;
    logic               landed_next;

    logic [9:0]         pos_int;
    logic [10:0]        floor_step;
    logic               side_hit;
    logic [13:0]        floor_pos;
    logic signed [14:0] floor_pos_s;
    logic signed [14:0] air_pos;
    logic signed [14:0] jump_pos;
    logic signed [11:0] vel_sum;
    logic signed [11:0] vel_cap;

    assign pos_int     = pos[13:4];
    assign floor_step  = {1'b0, floor_y} + 11'(STEP_MAX);
    assign side_hit    = {1'b0, pos_int} > floor_step;
    assign floor_pos   = {floor_y, 4'b0000};
    assign floor_pos_s = $signed({1'b0, floor_pos});
    // 15-bit signed sums so an upward move past the top of the screen shows as negative
    assign air_pos     = $signed({1'b0, pos}) + $signed({{3{vel[11]}}, vel});
    assign jump_pos    = $signed({1'b0, pos}) + $signed({{3{JUMP_V0[11]}}, JUMP_V0});
    assign vel_sum     = vel + GRAV;
    assign vel_cap     = (vel_sum > MAX_V) ? MAX_V : vel_sum;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state  <= GROUNDED;
            pos    <= GROUND_POS;
            vel    <= '0;
            landed <= 1'b0;
        end else begin
            state  <= state_next;
            pos    <= pos_next;
            vel    <= vel_next;
            landed <= landed_next;
        end
    end

    always_comb begin
        state_next  = state;
        pos_next    = pos;
        vel_next    = vel;
        landed_next = 1'b0;
        if (frame_tick && enable) begin
            case (state)
                GROUNDED: begin
                    if (side_hit) begin
                        state_next = CRASHED;
                    end else if (pos_int > floor_y) begin
                        pos_next = floor_pos;
                    end else if (jump) begin
                        pos_next   = (jump_pos < 0) ? 14'd0 : jump_pos[13:0];
                        vel_next   = JUMP_V0 + GRAV;
                        state_next = AIR;
                    end else if (floor_y > pos_int) begin
                        vel_next   = GRAV;
                        state_next = AIR;
                    end
                end
                AIR: begin
                    if (air_pos < 0) begin
                        pos_next = '0;
                        vel_next = '0;
                    end else if (air_pos >= floor_pos_s) begin
                        if (side_hit) begin
                            state_next = CRASHED;
                        end else begin
                            pos_next    = floor_pos;
                            vel_next    = '0;
                            state_next  = GROUNDED;
                            landed_next = 1'b1;
                        end
                    end else begin
                        pos_next = air_pos[13:0];
                        vel_next = vel_cap;
                    end
                end
                default: ;
            endcase
        end
    end

    assign player_y_pos = {6'b0, pos_int};
    assign on_ground    = (state == GROUNDED);
    assign crash        = (state == CRASHED);

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics: ground idle, jump arc, landing pulse,
// walk-off fall, terminal velocity, step/crash, pause, restart and reset.
module tb_player_physics;

    logic        clk = 1'b0;
    logic        reset, frame_tick, enable, restart, jump;
    logic [9:0]  floor_y;
    logic [15:0] player_y_pos;
    logic        on_ground, landed, crash;

    int total  = 0;
    int passed = 0;

    player_physics dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .enable       (enable),
        .restart      (restart),
        .jump         (jump),
        .floor_y      (floor_y),
        .player_y_pos (player_y_pos),
        .on_ground    (on_ground),
        .landed       (landed),
        .crash        (crash)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; restart = 1'b0;
        jump = 1'b0; floor_y = 10'd400;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_y", player_y_pos, 400);
        check("reset_on_ground", on_ground, 1);
        check("reset_landed", landed, 0);
        check("reset_crash", crash, 0);

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_y", player_y_pos, 400);
            check("idle_ground", on_ground, 1);
            check("idle_landed", landed, 0);
            check("idle_crash", crash, 0);
        end

        // single-tick jump
        jump = 1'b1; tick(); jump = 1'b0;
        check("jump_t1_y", player_y_pos, 390);
        check("jump_t1_ground", on_ground, 0);
        tick();
        check("jump_t2_y", player_y_pos, 380);
        ticks(14);
        check("jump_apex_t16", player_y_pos, 315);
        tick();
        check("jump_apex_t17", player_y_pos, 315);
        ticks(15);
        check("jump_t32_y", player_y_pos, 390);
        check("jump_t32_landed", landed, 0);
        tick();
        check("land_t33_y", player_y_pos, 400);
        check("land_t33_pulse", landed, 1);
        check("land_t33_ground", on_ground, 1);
        @(negedge clk);
        check("land_pulse_clear", landed, 0);

        // jump held continuously
        jump = 1'b1;
        ticks(33);
        check("hold_land_y", player_y_pos, 400);
        check("hold_land_pulse", landed, 1);
        tick();
        check("hold_rejump_y", player_y_pos, 390);
        check("hold_rejump_landed", landed, 0);
        jump = 1'b0;
        ticks(32);
        check("hold_second_land", player_y_pos, 400);
        check("hold_second_ground", on_ground, 1);

        // restart coincident with a tick mid-air
        jump = 1'b1; tick(); jump = 1'b0;
        check("pre_restart_y", player_y_pos, 390);
        @(negedge clk) begin frame_tick = 1'b1; restart = 1'b1; end
        @(negedge clk) begin frame_tick = 1'b0; restart = 1'b0; end
        check("restart_tick_y", player_y_pos, 400);
        check("restart_tick_ground", on_ground, 1);

        // walk off an edge onto the no-floor value
        floor_y = 10'd480;
        tick();
        check("walk_t1_y", player_y_pos, 400);
        check("walk_t1_ground", on_ground, 0);
        tick();
        check("walk_t2_y", player_y_pos, 400);
        tick();
        check("walk_t3_y", player_y_pos, 401);
        tick();
        check("walk_t4_y", player_y_pos, 403);
        ticks(12);
        check("walk_t16_y", player_y_pos, 475);
        check("walk_t16_landed", landed, 0);
        tick();
        check("walk_land_y", player_y_pos, 480);
        check("walk_land_pulse", landed, 1);

        // long fall reaches terminal velocity (12 px per frame)
        pulse_restart();
        check("restart_y", player_y_pos, 400);
        jump = 1'b1; tick(); jump = 1'b0;
        ticks(35);
        check("fall_t36_y", player_y_pos, 433);
        tick();
        check("fall_t37_y", player_y_pos, 445);
        tick();
        check("fall_t38_y", player_y_pos, 457);
        tick();
        check("fall_t39_y", player_y_pos, 469);
        tick();
        check("fall_land_y", player_y_pos, 480);
        check("fall_land_pulse", landed, 1);

        // floor rises by exactly STEP_MAX, then beyond it
        pulse_restart();
        floor_y = 10'd396;
        tick();
        check("step_snap_y", player_y_pos, 396);
        check("step_snap_crash", crash, 0);
        check("step_snap_ground", on_ground, 1);
        floor_y = 10'd390;
        tick();
        check("side_crash", crash, 1);
        check("side_crash_y", player_y_pos, 396);
        check("side_crash_ground", on_ground, 0);
        jump = 1'b1; ticks(2); jump = 1'b0;
        check("crash_jump_y", player_y_pos, 396);
        check("crash_sticky", crash, 1);
        pulse_restart();
        check("crash_restart_y", player_y_pos, 400);
        check("crash_restart_crash", crash, 0);

        // pause mid-air, resume, then synchronous reset
        floor_y = 10'd400;
        jump = 1'b1; tick(); jump = 1'b0;
        tick();
        check("pause_pre_y", player_y_pos, 380);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pause_y", player_y_pos, 380);
            check("pause_ground", on_ground, 0);
        end
        enable = 1'b1;
        tick();
        check("resume_y", player_y_pos, 371);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("midair_reset_y", player_y_pos, 400);
        check("midair_reset_ground", on_ground, 1);
        tick();
        check("post_reset_y", player_y_pos, 400);
        check("post_reset_landed", landed, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
